regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Writeback arbiter in front of the dual-write-port register file.
//  Shares the two write ports between three writers: lane0 (older issue slot), lane1 (younger slot) and LLU (long-latency unit: mul/div/load-miss).
//  Enforces in-order lane acceptance, same-cycle WAW resolution and LLU anti-starvation.
//  Drives Write_Enable/Addr/Data_1/2 from registers, 1 cycle after acceptance.
// PARAMETERS
//  STARVE_LIMIT  4   consecutive stalled LLU cycles before LLU gets top priority (>=1)
//  CNT_W         32  width of statistics counters (only with RF_ARB_STATS_EN)
// PORTS
//  clk             in   1   clock, rising edge
//  resetn          in   1   asynchronous, active-low reset
//  l0_valid        in   1   lane0 writeback request
//  l0_addr         in   5   lane0 destination register
//  l0_data         in   32  lane0 result
//  l0_ready        out  1   lane0 accepted this cycle (combinational)
//  l1_valid/l1_addr/l1_data/l1_ready   same as lane0, for lane1
//  llu_valid/llu_addr/llu_data/llu_ready  same as lane0, for LLU
//  Write_Enable_1  out  1   regfile port 1 write enable (registered)
//  Write_Addr_1    out  5   regfile port 1 address (registered)
//  Write_Data_1    out  32  regfile port 1 data (registered)
//  Write_Enable_2/Write_Addr_2/Write_Data_2  out 1/5/32  port 2, same rules
//  stat_stall_cnt  out  CNT_W  LLU stalled cycles (RF_ARB_STATS_EN only)
//  stat_waw_cnt    out  CNT_W  suppressed WAW writes (RF_ARB_STATS_EN only)
// BEHAVIOUR
//  Handshake: transfer when valid&&ready; requester holds valid and payload stable until ready. ready may be high while valid is low.
//  Age order, oldest first: LLU < lane0 < lane1.
//  age_cnt, width $clog2(STARVE_LIMIT+1):
//   +1 per cycle llu_valid&&!llu_ready, saturating at STARVE_LIMIT.
//   Cleared on LLU acceptance or when llu_valid is low.
//  States: NORMAL (age_cnt<STARVE_LIMIT), URGENT (age_cnt==STARVE_LIMIT).
//  Two slots per cycle, filled by valid requesters in priority order:
//   NORMAL: lane0, lane1, LLU.
//   URGENT: LLU, lane0, lane1.
//  In-order rule: lane1 never accepted in a cycle where lane0 is valid and not accepted.
//  Port mapping: oldest accepted request goes to port 1, the next to port 2; unused port has Write_Enable=0.
//  WAW: if two accepted requests share a nonzero addr, the older is acked but dropped.
//   The younger goes to port 1; port 2 is disabled.
//  Addr 0: request is acked; its Write_Enable stays 0.
//   It never counts as a WAW conflict and still occupies a slot.
//  Latency: write on regfile ports exactly 1 clk after acceptance; outputs cleared the next clk if nothing is accepted.
//  Reset, async assert: all Write_* outputs 0, age_cnt 0, state NORMAL, stat counters 0.
//   Registered writes still pending are discarded.
//   While resetn=0, all ready outputs are 0.
//  Write_Data/Write_Addr are don't-care when Write_Enable is 0, but are driven to 0.
// CONFIGURATION
//  `RF_ARB_STATS_EN defined:
//   stat_stall_cnt +1 each cycle llu_valid&&!llu_ready.
//   stat_waw_cnt +1 per dropped WAW write.
//   Both wrap at 2^CNT_W.
//  Not defined: stat ports tied to 0 and counters not instantiated.
// TESTING
//  1. l0(r3,0xA), l1(r4,0xB) valid -> both ready; next clk WE1=1 A1=3 D1=0xA, WE2=1 A2=4 D2=0xB.
//  2. l0(r5,0x1), l1(r5,0x2) valid -> both acked; next clk WE1=1 A1=5 D1=0x2, WE2=0; stat_waw_cnt=1.
//  3. l0,l1,LLU valid every cycle, STARVE_LIMIT=4 -> llu_ready low for 4 clks, then high together with l0; l1_ready=0; next clk port1=LLU, port2=lane0.
//  4. l0_valid=0 (l0_ready still 1), l1(r7) and LLU(r9) valid -> l1 and LLU accepted; next clk port1=LLU r9, port2=lane1 r7.
//  5. l0(r0,0x5) valid alone -> l0_ready=1; next clk WE1=WE2=0.
//  6. resetn low mid-stream, the cycle after acceptance -> WE1/WE2 drop to 0 at once; after release, age_cnt=0 and state NORMAL.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter sharing two regfile write ports among lane0, lane1 and LLU.
// Optional statistics counters are enabled with `RF_ARB_STATS_EN.
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             l0_valid,
  input  logic [4:0]       l0_addr,
  input  logic [31:0]      l0_data,
  output logic             l0_ready,
  input  logic             l1_valid,
  input  logic [4:0]       l1_addr,
  input  logic [31:0]      l1_data,
  output logic             l1_ready,
  input  logic             llu_valid,
  input  logic [4:0]       llu_addr,
  input  logic [31:0]      llu_data,
  output logic             llu_ready,
  output logic             Write_Enable_1,
  output logic [4:0]       Write_Addr_1,
  output logic [31:0]      Write_Data_1,
  output logic             Write_Enable_2,
  output logic [4:0]       Write_Addr_2,
  output logic [31:0]      Write_Data_2,
  output logic [CNT_W-1:0] stat_stall_cnt,
  output logic [CNT_W-1:0] stat_waw_cnt
);
  localparam int AW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW-1:0] LIM = AW'(STARVE_LIMIT);

  typedef enum logic {NORMAL, URGENT} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] age_q, age_d;
  logic          acc_l0, acc_l1, acc_llu;
  logic          a_v, b_v, waw;
  logic [4:0]    a_addr, b_addr, p1_addr, p2_addr;
  logic [31:0]   a_data, b_data, p1_data, p2_data;
  logic          p1_we, p2_we;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= NORMAL;
      age_q   <= '0;
    end else begin
      state_q <= state_d;
      age_q   <= age_d;
    end
  end

  // A requester's ready reflects whether it would win a slot,
  // so it can be high even while its own valid is low.
  always_comb begin
    l0_ready  = 1'b0;
    l1_ready  = 1'b0;
    llu_ready = 1'b0;
    if (resetn) begin
      unique case (state_q)
        NORMAL: begin
          l0_ready  = 1'b1;
          l1_ready  = 1'b1;
          llu_ready = !(l0_valid && l1_valid);
        end
        URGENT: begin
          llu_ready = 1'b1;
          l0_ready  = 1'b1;
          l1_ready  = !(llu_valid && l0_valid);
        end
        default: ;
      endcase
    end
  end

  assign acc_l0  = l0_valid && l0_ready;
  assign acc_l1  = l1_valid && l1_ready;
  assign acc_llu = llu_valid && llu_ready;

  always_comb begin
    age_d = age_q;
    if (!llu_valid || acc_llu)
      age_d = '0;
    else if (age_q != LIM)
      age_d = age_q + 1'b1;
    state_d = (age_d == LIM) ? URGENT : NORMAL;
  end

  // a = oldest accepted, b = next oldest
  always_comb begin
    a_v    = 1'b0;
    a_addr = '0;
    a_data = '0;
    b_v    = 1'b0;
    b_addr = '0;
    b_data = '0;
    if (acc_llu) begin
      a_v    = 1'b1;
      a_addr = llu_addr;
      a_data = llu_data;
      b_v    = acc_l0 || acc_l1;
      b_addr = acc_l0 ? l0_addr : l1_addr;
      b_data = acc_l0 ? l0_data : l1_data;
    end else if (acc_l0) begin
      a_v    = 1'b1;
      a_addr = l0_addr;
      a_data = l0_data;
      b_v    = acc_l1;
      b_addr = l1_addr;
      b_data = l1_data;
    end else begin
      a_v    = acc_l1;
      a_addr = l1_addr;
      a_data = l1_data;
    end
  end

  assign waw = a_v && b_v && (a_addr == b_addr) && (a_addr != 5'd0);

  always_comb begin
    p1_we   = waw ? 1'b1 : (a_v && a_addr != 5'd0);
    p1_addr = waw ? b_addr : a_addr;
    p1_data = waw ? b_data : a_data;
    p2_we   = !waw && b_v && b_addr != 5'd0;
    p2_addr = b_addr;
    p2_data = b_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      Write_Enable_1 <= 1'b0;
      Write_Addr_1   <= '0;
      Write_Data_1   <= '0;
      Write_Enable_2 <= 1'b0;
      Write_Addr_2   <= '0;
      Write_Data_2   <= '0;
    end else begin
      Write_Enable_1 <= p1_we;
      Write_Addr_1   <= p1_we ? p1_addr : 5'd0;
      Write_Data_1   <= p1_we ? p1_data : 32'd0;
      Write_Enable_2 <= p2_we;
      Write_Addr_2   <= p2_we ? p2_addr : 5'd0;
      Write_Data_2   <= p2_we ? p2_data : 32'd0;
    end
  end

`ifdef RF_ARB_STATS_EN
  logic [CNT_W-1:0] stall_q, waw_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_q <= '0;
      waw_q   <= '0;
    end else begin
      if (llu_valid && !llu_ready)
        stall_q <= stall_q + 1'b1;
      if (waw)
        waw_q <= waw_q + 1'b1;
    end
  end

  assign stat_stall_cnt = stall_q;
  assign stat_waw_cnt   = waw_q;
`else
  assign stat_stall_cnt = '0;
  assign stat_waw_cnt   = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vector table plus
// starvation and reset sequences.
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        resetn;
  logic        l0_valid, l1_valid, llu_valid;
  logic [4:0]  l0_addr, l1_addr, llu_addr;
  logic [31:0] l0_data, l1_data, llu_data;
  logic        l0_ready, l1_ready, llu_ready;
  logic        we1, we2;
  logic [4:0]  a1, a2;
  logic [31:0] d1, d2;
  logic [31:0] stall_cnt, waw_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  regfile_wb_arbiter #(.STARVE_LIMIT(4), .CNT_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .l0_valid(l0_valid), .l0_addr(l0_addr),
    .l0_data(l0_data), .l0_ready(l0_ready),
    .l1_valid(l1_valid), .l1_addr(l1_addr),
    .l1_data(l1_data), .l1_ready(l1_ready),
    .llu_valid(llu_valid), .llu_addr(llu_addr),
    .llu_data(llu_data), .llu_ready(llu_ready),
    .Write_Enable_1(we1), .Write_Addr_1(a1),
    .Write_Data_1(d1),
    .Write_Enable_2(we2), .Write_Addr_2(a2),
    .Write_Data_2(d2),
    .stat_stall_cnt(stall_cnt),
    .stat_waw_cnt(waw_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        l0v, l1v, lluv;
    logic [4:0]  l0a, l1a, llua;
    logic [31:0] l0d, l1d, llud;
    logic [2:0]  rdy;
    logic        e1, e2;
    logic [4:0]  ea1, ea2;
    logic [31:0] ed1, ed2;
  } vec_t;

  vec_t vt[11];

  function automatic vec_t mk(
    input logic l0v, input logic [4:0] l0a, input logic [31:0] l0d,
    input logic l1v, input logic [4:0] l1a, input logic [31:0] l1d,
    input logic lv, input logic [4:0] la, input logic [31:0] ld,
    input logic [2:0] rdy,
    input logic e1, input logic [4:0] ea1, input logic [31:0] ed1,
    input logic e2, input logic [4:0] ea2, input logic [31:0] ed2);
    vec_t v;
    v.l0v = l0v; v.l0a = l0a; v.l0d = l0d;
    v.l1v = l1v; v.l1a = l1a; v.l1d = l1d;
    v.lluv = lv; v.llua = la; v.llud = ld;
    v.rdy = rdy;
    v.e1 = e1; v.ea1 = ea1; v.ed1 = ed1;
    v.e2 = e2; v.ea2 = ea2; v.ed2 = ed2;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    l0_valid = v.l0v; l0_addr = v.l0a; l0_data = v.l0d;
    l1_valid = v.l1v; l1_addr = v.l1a; l1_data = v.l1d;
    llu_valid = v.lluv; llu_addr = v.llua; llu_data = v.llud;
  endtask

  task automatic chk_rdy(input string nm, input logic [2:0] e);
    chk({nm, ".rdy"}, {29'd0, l0_ready, l1_ready, llu_ready},
        {29'd0, e});
  endtask

  task automatic chk_out(input string nm,
                         input logic e1, input logic [4:0] ea1,
                         input logic [31:0] ed1,
                         input logic e2, input logic [4:0] ea2,
                         input logic [31:0] ed2);
    chk({nm, ".we1"}, {31'd0, we1}, {31'd0, e1});
    chk({nm, ".a1"}, {27'd0, a1}, {27'd0, ea1});
    chk({nm, ".d1"}, d1, ed1);
    chk({nm, ".we2"}, {31'd0, we2}, {31'd0, e2});
    chk({nm, ".a2"}, {27'd0, a2}, {27'd0, ea2});
    chk({nm, ".d2"}, d2, ed2);
  endtask

  vec_t all3, idle;

  initial begin
    vt[0]  = mk(1,3,32'hA, 1,4,32'hB, 0,0,0, 3'b110,
                1,3,32'hA, 1,4,32'hB);
    vt[1]  = mk(1,5,32'h1, 1,5,32'h2, 0,0,0, 3'b110,
                1,5,32'h2, 0,0,0);
    vt[2]  = mk(0,0,0, 1,7,32'h77, 1,9,32'h99, 3'b111,
                1,9,32'h99, 1,7,32'h77);
    vt[3]  = mk(1,0,32'h5, 0,0,0, 0,0,0, 3'b111,
                0,0,0, 0,0,0);
    vt[4]  = mk(0,0,0, 0,0,0, 1,10,32'h1010, 3'b111,
                1,10,32'h1010, 0,0,0);
    vt[5]  = mk(1,6,32'h66, 0,0,0, 1,6,32'h67, 3'b111,
                1,6,32'h66, 0,0,0);
    vt[6]  = mk(0,0,0, 0,0,0, 0,0,0, 3'b111,
                0,0,0, 0,0,0);
    vt[7]  = mk(1,0,32'h1, 1,0,32'h2, 0,0,0, 3'b110,
                0,0,0, 0,0,0);
    vt[8]  = mk(1,8,32'h88, 1,0,32'h1, 0,0,0, 3'b110,
                1,8,32'h88, 0,0,0);
    vt[9]  = mk(1,0,32'h3, 0,0,0, 1,0,32'h4, 3'b111,
                0,0,0, 0,0,0);
    vt[10] = mk(0,0,0, 1,30,32'h1E, 1,31,32'hFFFFFFFF, 3'b111,
                1,31,32'hFFFFFFFF, 1,30,32'h1E);
    all3 = mk(1,1,32'h11, 1,2,32'h22, 1,3,32'h33, 3'b000,
              0,0,0, 0,0,0);
    idle = vt[6];

    resetn = 1'b0;
    drive(vt[0]);
    #2;
    chk_rdy("reset", 3'b000);
    chk_out("reset", 0,0,0, 0,0,0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 11; i++) begin
      drive(vt[i]);
      #1;
      chk_rdy($sformatf("vec%0d", i), vt[i].rdy);
      @(posedge clk);
      #1;
      chk_out($sformatf("vec%0d", i), vt[i].e1, vt[i].ea1, vt[i].ed1,
              vt[i].e2, vt[i].ea2, vt[i].ed2);
      @(negedge clk);
    end

    // LLU starves for four cycles, then wins alongside lane0
    for (int k = 0; k < 5; k++) begin
      drive(all3);
      #1;
      chk_rdy($sformatf("starve%0d", k),
              (k == 4) ? 3'b101 : 3'b110);
      @(posedge clk);
      #1;
      if (k == 4)
        chk_out("starve_out", 1,3,32'h33, 1,1,32'h11);
      else
        chk_out($sformatf("starve%0d", k), 1,1,32'h11, 1,2,32'h22);
      @(negedge clk);
    end
    drive(idle);
    #1;
    chk_rdy("post_starve", 3'b111);
    @(posedge clk);
    #1;
    chk_out("post_starve", 0,0,0, 0,0,0);
`ifdef RF_ARB_STATS_EN
    chk("stat_waw", waw_cnt, 32'd2);
    chk("stat_stall", stall_cnt, 32'd4);
`else
    chk("stat_waw", waw_cnt, 32'd0);
    chk("stat_stall", stall_cnt, 32'd0);
`endif
    @(negedge clk);

    // reset the cycle after an acceptance, with LLU partly aged
    drive(all3);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    chk_out("pre_rst", 1,1,32'h11, 1,2,32'h22);
    resetn = 1'b0;
    #1;
    chk_out("in_rst", 0,0,0, 0,0,0);
    chk_rdy("in_rst", 3'b000);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk_rdy($sformatf("rst_age%0d", k),
              (k == 4) ? 3'b101 : 3'b110);
      @(posedge clk);
      @(negedge clk);
    end
`ifdef RF_ARB_STATS_EN
    chk("stat_stall_rst", stall_cnt, 32'd4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
